// File: rtl/key_pkg.sv
// Shared definitions for key conditioning: FSM encodings and 50 MHz timing defaults.
package key_pkg;

  localparam int CNT_W  = 20;
  localparam int HOLD_W = 25;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX_DEF    = 20'd999_999;
  localparam logic [HOLD_W-1:0] LONG_MAX_DEF   = 25'd24_999_999;
  localparam logic [HOLD_W-1:0] REPEAT_MAX_DEF = 25'd4_999_999;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; 2-cycle latency, reset value selectable.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low key into press/release pulses and a level; press/release confirmed
// CNT_MAX+4 cycles after the pin settles. Optional auto-repeat under KEY_REPEAT_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter logic [CNT_W-1:0]  CNT_MAX    = CNT_MAX_DEF,
  parameter logic [HOLD_W-1:0] LONG_MAX   = LONG_MAX_DEF,
  parameter logic [HOLD_W-1:0] REPEAT_MAX = REPEAT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_state,
  output logic key_repeat
);

  logic             key_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Idle level of the pin is high, so the synchroniser resets to 1.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (key_in),
    .q         (key_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        PRESSED: begin
          if (key_s) begin
            state <= REL_DB;
            cnt   <= '0;
          end
        end
        REL_DB: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  logic [HOLD_W-1:0] hold_cnt;

  // After each repeat the counter rewinds so the next hit is REPEAT_MAX+1 cycles later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt   <= '0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if (state == PRESSED && !key_s) begin
        if (hold_cnt == LONG_MAX) begin
          key_repeat <= 1'b1;
          hold_cnt   <= LONG_MAX - REPEAT_MAX;
        end else begin
          hold_cnt <= hold_cnt + 25'd1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{LONG_MAX, REPEAT_MAX};
  assign key_repeat        = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int CM = 9;
  localparam int LM = 49;
  localparam int RM = 19;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic key_in    = 1'b1;
  logic key_flag, key_release, key_state, key_repeat;

  int total = 0;
  int bad   = 0;

  // Reference model: pin seen two edges late, then stable-run lengths decide events.
  logic p1 = 1'b1, p2 = 1'b1;
  bit   pressed = 0;
  int   lrun = 0, hrun = 0, held_start = 0, cyc = 0;
  int   nflag = 0, nrel = 0, nrep = 0;

  key_debounce #(
    .CNT_MAX    (20'(CM)),
    .LONG_MAX   (25'(LM)),
    .REPEAT_MAX (25'(RM))
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .key_release (key_release),
    .key_state   (key_state),
    .key_repeat  (key_repeat)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    p1 = 1'b1; p2 = 1'b1;
    pressed = 0; lrun = 0; hrun = 0; held_start = 0;
  endtask

  task automatic step(input logic v);
    logic d;
    bit   ef, er, erp;
    int   age;
    key_in = v;
    @(posedge sys_clk);
    cyc++;
    d  = p2;
    p2 = p1;
    p1 = v;
    ef = 0; er = 0; erp = 0;
    if (!pressed) begin
      lrun = d ? 0 : lrun + 1;
      if (lrun == CM + 2) begin
        ef = 1; pressed = 1; hrun = 0; held_start = cyc;
      end
    end else if (d) begin
      hrun++;
      if (hrun == CM + 2) begin
        er = 1; pressed = 0; lrun = 0;
      end
    end else begin
      if (hrun > 0) held_start = cyc;
      hrun = 0;
      age  = cyc - held_start;
`ifdef KEY_REPEAT_EN
      if (age > LM && (age - LM - 1) % (RM + 1) == 0) erp = 1;
`else
      if (age < 0) erp = 0;
`endif
    end
    #1;
    chk("key_flag", 32'(key_flag), 32'(ef));
    chk("key_release", 32'(key_release), 32'(er));
    chk("key_state", 32'(key_state), 32'(pressed));
    chk("key_repeat", 32'(key_repeat), 32'(erp));
    chk("flag_rel_excl", 32'(key_flag & key_release), 32'd0);
    nflag += int'(key_flag);
    nrel  += int'(key_release);
    nrep  += int'(key_repeat);
  endtask

  task automatic steps(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic do_reset(input logic v, input int n);
    key_in = v;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_flag", 32'(key_flag), 32'd0);
    chk("rst_release", 32'(key_release), 32'd0);
    chk("rst_state", 32'(key_state), 32'd0);
    chk("rst_repeat", 32'(key_repeat), 32'd0);
    repeat (n) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic clr_counts();
    nflag = 0; nrel = 0; nrep = 0;
  endtask

  initial begin
    int len;
    logic v;
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("init_flag", 32'(key_flag), 32'd0);
    chk("init_state", 32'(key_state), 32'd0);
    repeat (3) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    model_reset();
    steps(1'b1, 5);

    // Clean press
    clr_counts();
    steps(1'b0, 40);
    chk("clean_nflag", 32'(nflag), 32'd1);
    chk("clean_nrel", 32'(nrel), 32'd0);

    // Release with a 3-cycle low bounce
    clr_counts();
    steps(1'b1, 4);
    steps(1'b0, 3);
    steps(1'b1, 20);
    chk("rel_nrel", 32'(nrel), 32'd1);
    chk("rel_nflag", 32'(nflag), 32'd0);

    // Bouncy press
    clr_counts();
    steps(1'b0, 5);
    steps(1'b1, 2);
    steps(1'b0, 20);
    chk("bouncy_nflag", 32'(nflag), 32'd1);
    steps(1'b1, 20);

    // Short glitch
    clr_counts();
    steps(1'b0, 8);
    steps(1'b1, 15);
    chk("glitch_nflag", 32'(nflag), 32'd0);

    // Long hold for auto-repeat
    clr_counts();
    steps(1'b0, 13);
    steps(1'b0, 100);
    steps(1'b1, 20);
`ifdef KEY_REPEAT_EN
    chk("hold_nrep", 32'(nrep), 32'd3);
`else
    chk("hold_nrep", 32'(nrep), 32'd0);
`endif
    chk("hold_nrel", 32'(nrel), 32'd1);

    // Reset while pressed, key kept low
    steps(1'b0, 30);
    do_reset(1'b0, 3);
    clr_counts();
    steps(1'b0, 20);
    chk("rstpress_nflag", 32'(nflag), 32'd1);
    chk("rstpress_nrel", 32'(nrel), 32'd0);
    steps(1'b1, 20);

    // Random runs of bouncing and stable levels
    for (int s = 0; s < 80; s++) begin
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 90))
                                        : int'($urandom_range(1, 14));
      if ($urandom_range(0, 24) == 0) do_reset(v, 2);
      steps(v, len);
    end
    steps(1'b1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
